usb_reg_bridge: RTL and testbench

Parametrised successor to the USB-chip-to-register-bus bridge. It synchronises the external USB chip strobes (rdn/wrn/cen/alen) and sequences register reads and writes through an explicit state machine. It adds configurable read latency, output-enable turnaround, address width and byte-count width, plus a sticky protocol-error flag. It sits between the USB chip pins and all register blocks on clk_usb, and keeps the fast-FIFO bus-hold mode.

---
 rtl/usb_reg_bridge_if.sv | 43 ++++
 rtl/usb_reg_bridge.sv | 175 +++++++++++++++++
 tb/tb_usb_reg_bridge.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_reg_bridge_if.sv
// usb_reg_bridge_if
// Purpose: bundles the USB chip pin signals and the register-bus signals that
// usb_reg_bridge sits between. The _i/_o suffixes are from the bridge's view.
// Modports:
//   master - the bridge: samples USB pins and reg_datai, drives the register
//            bus, the data pins and their output enable.
//   slave  - the far side (USB chip pins plus register blocks, or a bench).
interface usb_reg_bridge_if #(
  parameter int pADDR_WIDTH   = 8,
  parameter int pBYTECNT_SIZE = 7
);
  logic [7:0]               cwusb_din_i;
  logic [7:0]               cwusb_dout_o;
  logic                     cwusb_isout_o;
  logic [pADDR_WIDTH-1:0]   cwusb_addr_i;
  logic                     cwusb_rdn_i;
  logic                     cwusb_wrn_i;
  logic                     cwusb_cen_i;
  logic                     cwusb_alen_i;
  logic                     fast_fifo_read_i;
  logic [pADDR_WIDTH-1:0]   reg_address_o;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt_o;
  logic [7:0]               reg_datao_o;
  logic [7:0]               reg_datai_i;
  logic                     reg_read_o;
  logic                     reg_write_o;
  logic                     reg_addrvalid_o;
  logic                     proto_err_o;

  modport master (
    input  cwusb_din_i, cwusb_addr_i, cwusb_rdn_i, cwusb_wrn_i, cwusb_cen_i,
           cwusb_alen_i, fast_fifo_read_i, reg_datai_i,
    output cwusb_dout_o, cwusb_isout_o, reg_address_o, reg_bytecnt_o,
           reg_datao_o, reg_read_o, reg_write_o, reg_addrvalid_o, proto_err_o
  );

  modport slave (
    output cwusb_din_i, cwusb_addr_i, cwusb_rdn_i, cwusb_wrn_i, cwusb_cen_i,
           cwusb_alen_i, fast_fifo_read_i, reg_datai_i,
    input  cwusb_dout_o, cwusb_isout_o, reg_address_o, reg_bytecnt_o,
           reg_datao_o, reg_read_o, reg_write_o, reg_addrvalid_o, proto_err_o
  );
endinterface

// File: rtl/usb_reg_bridge.sv
// usb_reg_bridge
// Purpose: bridges the USB chip's asynchronous strobe interface onto the
// internal register bus. Strobes are synchronised onto clk_usb_i, edges are
// detected, and an FSM (IDLE/RD/TURN/WR/COMMIT) issues one-cycle reg_read /
// reg_write pulses, tracks the byte index, controls the data-pin output
// enable (with a read turnaround) and flags illegal rd+wr overlap.
// Ports:
//   clk_usb_i - USB interface clock
//   reset_i   - asynchronous active-high reset
//   bus       - usb_reg_bridge_if.master: USB pins and register bus
module usb_reg_bridge #(
  parameter int pADDR_WIDTH   = 8,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pSYNC_STAGES  = 2,
  parameter int pREAD_LATENCY = 1,
  parameter int pTURNAROUND   = 2
) (
  input logic               clk_usb_i,
  input logic               reset_i,
  usb_reg_bridge_if.master  bus
);

  typedef enum logic [2:0] {IDLE, RD, TURN, WR, COMMIT} state_e;

  localparam logic [2:0] TURN_LOAD = (pTURNAROUND > 0) ? 3'(pTURNAROUND - 1) : 3'd0;

  state_e                   state_q;
  logic [2:0]               turnCnt_q;
  logic [pSYNC_STAGES-1:0]  rdnSync_q, wrnSync_q, cenSync_q, alenSync_q;
  logic                     rdnPrev_q, wrnPrev_q;
  logic [pADDR_WIDTH-1:0]   reg_address_q;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt_q;
  logic [7:0]               reg_datao_q;
  logic                     reg_write_q;
  logic                     proto_err_q;
  logic [pREAD_LATENCY-1:0] rdPipe_q;
  logic [7:0]               cwusb_dout_q;
  logic                     drive_q;
  logic                     ffrPrev_q;

  logic rdn_s, wrn_s, cen_s, alen_s;
  logic rdStart, wrStart, wrEnd, protoHit, readFire;

  assign rdn_s  = rdnSync_q[pSYNC_STAGES-1];
  assign wrn_s  = wrnSync_q[pSYNC_STAGES-1];
  assign cen_s  = cenSync_q[pSYNC_STAGES-1];
  assign alen_s = alenSync_q[pSYNC_STAGES-1];

  assign rdStart  = !cen_s && rdnPrev_q && !rdn_s;
  assign wrStart  = !cen_s && wrnPrev_q && !wrn_s;
  assign wrEnd    = !wrnPrev_q && wrn_s;
  assign protoHit = !cen_s && !rdn_s && !wrn_s;
  // A read is accepted from IDLE or TURN; reads win over writes there, and
  // an rd+wr overlap suppresses everything.
  assign readFire = !protoHit && rdStart && (state_q == IDLE || state_q == TURN);

  // Strobe synchronisers. They reset to the inactive (high) level so that
  // leaving reset with the pins idle produces no spurious edges.
  always_ff @(posedge clk_usb_i or posedge reset_i) begin
    if (reset_i) begin
      rdnSync_q  <= '1;
      wrnSync_q  <= '1;
      cenSync_q  <= '1;
      alenSync_q <= '1;
      rdnPrev_q  <= 1'b1;
      wrnPrev_q  <= 1'b1;
    end else begin
      rdnSync_q  <= {rdnSync_q[pSYNC_STAGES-2:0], bus.cwusb_rdn_i};
      wrnSync_q  <= {wrnSync_q[pSYNC_STAGES-2:0], bus.cwusb_wrn_i};
      cenSync_q  <= {cenSync_q[pSYNC_STAGES-2:0], bus.cwusb_cen_i};
      alenSync_q <= {alenSync_q[pSYNC_STAGES-2:0], bus.cwusb_alen_i};
      rdnPrev_q  <= rdn_s;
      wrnPrev_q  <= wrn_s;
    end
  end

  // Transaction FSM with registered outputs. The rd+wr overlap check sits
  // above the state case so it aborts any transaction. The alen clear is the
  // last assignment to the byte counter so it overrides any increment made
  // by the state case in the same cycle.
  always_ff @(posedge clk_usb_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      turnCnt_q     <= '0;
      reg_address_q <= '0;
      reg_bytecnt_q <= '0;
      reg_datao_q   <= '0;
      reg_write_q   <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      reg_write_q <= 1'b0;
      if (protoHit) begin
        proto_err_q <= 1'b1;
        state_q     <= IDLE;
      end else begin
        unique case (state_q)
          IDLE, TURN: begin
            if (rdStart) begin
              state_q       <= RD;
              reg_address_q <= bus.cwusb_addr_i;
            end else if (wrStart) begin
              state_q       <= WR;
              reg_address_q <= bus.cwusb_addr_i;
              reg_datao_q   <= bus.cwusb_din_i;
            end else if (state_q == TURN) begin
              if (turnCnt_q == 3'd0) state_q <= IDLE;
              else turnCnt_q <= turnCnt_q - 3'd1;
            end
          end
          RD: begin
            if (rdn_s) begin
              reg_bytecnt_q <= reg_bytecnt_q + 1'b1;
              turnCnt_q     <= TURN_LOAD;
              state_q       <= (pTURNAROUND == 0) ? IDLE : TURN;
            end
          end
          WR: begin
            if (wrEnd) begin
              state_q     <= COMMIT;
              reg_write_q <= 1'b1;
            end else if (!wrn_s) begin
              reg_datao_q <= bus.cwusb_din_i;
            end
          end
          COMMIT: begin
            state_q       <= IDLE;
            reg_bytecnt_q <= reg_bytecnt_q + 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
      if (!alen_s) reg_bytecnt_q <= '0;
    end
  end

  // Read-data pipeline. Stage 0 is the reg_read pulse itself; the last stage
  // marks the cycle whose closing edge captures reg_datai, giving exactly
  // pREAD_LATENCY cycles from the pulse to the captured value.
  always_ff @(posedge clk_usb_i or posedge reset_i) begin
    if (reset_i) begin
      rdPipe_q     <= '0;
      cwusb_dout_q <= '0;
    end else begin
      rdPipe_q[0] <= readFire;
      for (int i = 1; i < pREAD_LATENCY; i++) rdPipe_q[i] <= rdPipe_q[i-1];
      if (rdPipe_q[pREAD_LATENCY-1]) cwusb_dout_q <= bus.reg_datai_i;
    end
  end

  // Fast-FIFO drive flag: armed by a rising edge of fast_fifo_read, dropped
  // as soon as the raw write strobe goes low (the clear takes priority).
  always_ff @(posedge clk_usb_i or posedge reset_i) begin
    if (reset_i) begin
      drive_q   <= 1'b0;
      ffrPrev_q <= 1'b0;
    end else begin
      ffrPrev_q <= bus.fast_fifo_read_i;
      if (!bus.cwusb_wrn_i) drive_q <= 1'b0;
      else if (bus.fast_fifo_read_i && !ffrPrev_q) drive_q <= 1'b1;
    end
  end

  // The raw wrn pin gates the streaming enable so the pins are released in
  // the same cycle the chip starts driving them.
  assign bus.cwusb_isout_o   = (state_q == RD) || (state_q == TURN) || (drive_q && bus.cwusb_wrn_i);
  assign bus.cwusb_dout_o    = drive_q ? bus.reg_datai_i : cwusb_dout_q;
  assign bus.reg_address_o   = reg_address_q;
  assign bus.reg_bytecnt_o   = reg_bytecnt_q;
  assign bus.reg_datao_o     = reg_datao_q;
  assign bus.reg_read_o      = rdPipe_q[0];
  assign bus.reg_write_o     = reg_write_q;
  assign bus.reg_addrvalid_o = (state_q != IDLE);
  assign bus.proto_err_o     = proto_err_q;

endmodule

// File: tb/tb_usb_reg_bridge.sv
// tb_usb_reg_bridge
// Purpose: self-checking bench for usb_reg_bridge (pREAD_LATENCY=3, other
// parameters at defaults). A table of transactions, hand-written sequences
// for the multi-cycle corners, and a randomised run against a
// transaction-level reference model (byte index = completed transactions
// modulo 128 since the last alen/reset, write data held until the next write).
module tb_usb_reg_bridge;

  logic clk = 1'b0;
  logic reset;

  int errors = 0;
  int checks = 0;

  int         rdPulses = 0;
  int         wrPulses = 0;
  logic [7:0] lastRdAddr, lastWrAddr, lastWrData;
  logic [6:0] lastRdCnt, lastWrCnt;

  typedef struct {
    bit         isWrite;
    logic [7:0] addr;
    logic [7:0] data;
    logic [6:0] expCnt;
    logic [7:0] expDatao;
  } vec_t;

  vec_t vecs [6];

  usb_reg_bridge_if #(.pADDR_WIDTH(8), .pBYTECNT_SIZE(7)) bus ();

  usb_reg_bridge #(
    .pADDR_WIDTH(8), .pBYTECNT_SIZE(7), .pSYNC_STAGES(2),
    .pREAD_LATENCY(3), .pTURNAROUND(2)
  ) dut (
    .clk_usb_i(clk),
    .reset_i(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Records register-bus pulses; sampled on the falling edge, away from the
  // edge that updates them.
  always @(negedge clk) begin
    if (bus.reg_read_o) begin
      rdPulses   <= rdPulses + 1;
      lastRdAddr <= bus.reg_address_o;
      lastRdCnt  <= bus.reg_bytecnt_o;
    end
    if (bus.reg_write_o) begin
      wrPulses   <= wrPulses + 1;
      lastWrAddr <= bus.reg_address_o;
      lastWrData <= bus.reg_datao_o;
      lastWrCnt  <= bus.reg_bytecnt_o;
    end
  end

  // Hard stop in case a sequence wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic alenPulse();
    bus.cwusb_alen_i = 1'b0;
    tick(4);
    bus.cwusb_alen_i = 1'b1;
    tick(3);
  endtask

  // One complete USB-side transaction; for reads, doutSeen is the data-pin
  // value while the read strobe is still held.
  task automatic applyStimulus(input bit isWrite, input logic [7:0] addr,
                               input logic [7:0] data, output logic [7:0] doutSeen);
    bus.cwusb_addr_i = addr;
    doutSeen = 8'h00;
    if (isWrite) begin
      bus.cwusb_din_i = data;
      bus.cwusb_wrn_i = 1'b0;
      tick(4);
      bus.cwusb_wrn_i = 1'b1;
      tick(6);
    end else begin
      bus.reg_datai_i = data;
      bus.cwusb_rdn_i = 1'b0;
      tick(7);
      doutSeen = bus.cwusb_dout_o;
      bus.cwusb_rdn_i = 1'b1;
      tick(7);
    end
  endtask

  initial begin
    int         preRd, preWr, highCnt, pulseAt, refCnt;
    bit         found, rWr;
    logic [7:0] doutSeen, rAddr, rData, refDatao;

    vecs[0] = '{1'b1, 8'h23, 8'hA5, 7'd0, 8'hA5};
    vecs[1] = '{1'b0, 8'h40, 8'h5C, 7'd1, 8'hA5};
    vecs[2] = '{1'b1, 8'h7F, 8'h00, 7'd2, 8'h00};
    vecs[3] = '{1'b0, 8'hFF, 8'hFF, 7'd3, 8'h00};
    vecs[4] = '{1'b1, 8'h00, 8'hFF, 7'd4, 8'hFF};
    vecs[5] = '{1'b0, 8'h01, 8'h00, 7'd5, 8'hFF};

    reset = 1'b1;
    bus.cwusb_din_i = 8'h00;  bus.cwusb_addr_i = 8'h00;  bus.reg_datai_i = 8'h00;
    bus.cwusb_rdn_i = 1'b1;   bus.cwusb_wrn_i = 1'b1;    bus.cwusb_cen_i = 1'b0;
    bus.cwusb_alen_i = 1'b1;  bus.fast_fifo_read_i = 1'b0;
    tick(3);
    checkOutput("reset_address", bus.reg_address_o, 0);
    checkOutput("reset_bytecnt", bus.reg_bytecnt_o, 0);
    checkOutput("reset_isout", bus.cwusb_isout_o, 0);
    checkOutput("reset_pulses", {bus.reg_read_o, bus.reg_write_o}, 0);
    checkOutput("reset_proto_err", bus.proto_err_o, 0);
    reset = 1'b0;
    tick(4);

    // Table-driven transactions after an alen clear.
    alenPulse();
    for (int i = 0; i < 6; i++) begin
      preRd = rdPulses; preWr = wrPulses;
      applyStimulus(vecs[i].isWrite, vecs[i].addr, vecs[i].data, doutSeen);
      checkOutput($sformatf("vec%0d_pulse_total", i), (rdPulses - preRd) + (wrPulses - preWr), 1);
      if (vecs[i].isWrite) begin
        checkOutput($sformatf("vec%0d_wr_pulses", i), wrPulses - preWr, 1);
        checkOutput($sformatf("vec%0d_wr_addr", i), lastWrAddr, vecs[i].addr);
        checkOutput($sformatf("vec%0d_wr_data", i), lastWrData, vecs[i].data);
        checkOutput($sformatf("vec%0d_wr_cnt", i), lastWrCnt, vecs[i].expCnt);
      end else begin
        checkOutput($sformatf("vec%0d_rd_pulses", i), rdPulses - preRd, 1);
        checkOutput($sformatf("vec%0d_rd_addr", i), lastRdAddr, vecs[i].addr);
        checkOutput($sformatf("vec%0d_rd_cnt", i), lastRdCnt, vecs[i].expCnt);
        checkOutput($sformatf("vec%0d_rd_dout", i), doutSeen, vecs[i].data);
      end
      checkOutput($sformatf("vec%0d_datao", i), bus.reg_datao_o, vecs[i].expDatao);
      checkOutput($sformatf("vec%0d_cnt_after", i), bus.reg_bytecnt_o, 32'(vecs[i].expCnt) + 1);
    end

    // Write pulse timing relative to the wrn release.
    preWr = wrPulses;
    bus.cwusb_addr_i = 8'h24; bus.cwusb_din_i = 8'h5A; bus.cwusb_wrn_i = 1'b0;
    tick(4);
    bus.cwusb_wrn_i = 1'b1;
    pulseAt = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (bus.reg_write_o && pulseAt == 0) pulseAt = k;
    end
    checkOutput("wr_pulse_delay", pulseAt, 3);
    checkOutput("wr_pulse_count", wrPulses - preWr, 1);
    checkOutput("wr_addr", lastWrAddr, 8'h24);
    checkOutput("wr_datao_held", bus.reg_datao_o, 8'h5A);
    checkOutput("wr_cnt_after", bus.reg_bytecnt_o, 7);

    // Read latency and output-enable turnaround.
    preRd = rdPulses;
    bus.reg_datai_i = 8'h5C; bus.cwusb_addr_i = 8'h42; bus.cwusb_rdn_i = 1'b0;
    found = 1'b0; pulseAt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (!found && bus.reg_read_o) begin
        found = 1'b1;
        pulseAt = k;
      end
      if (found) break;
    end
    checkOutput("rd_pulse_delay", pulseAt, 3);
    checkOutput("rd_isout_in_rd", bus.cwusb_isout_o, 1);
    tick(2);
    checkOutput("rd_dout_before_latency", bus.cwusb_dout_o, 8'h00);
    tick(1);
    checkOutput("rd_dout_at_latency", bus.cwusb_dout_o, 8'h5C);
    bus.cwusb_rdn_i = 1'b1;
    highCnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (bus.cwusb_isout_o) highCnt++;
    end
    checkOutput("rd_isout_tail", highCnt, 4);
    checkOutput("rd_pulse_count", rdPulses - preRd, 1);
    checkOutput("rd_cnt_after", bus.reg_bytecnt_o, 8);

    // 130-byte burst: the 7-bit byte index wraps.
    alenPulse();
    preRd = rdPulses;
    for (int i = 0; i < 130; i++) begin
      bus.cwusb_rdn_i = 1'b0;
      tick(4);
      bus.cwusb_rdn_i = 1'b1;
      tick(5);
      if (i == 127) checkOutput("burst_wrap_to_zero", bus.reg_bytecnt_o, 0);
    end
    checkOutput("burst_pulses", rdPulses - preRd, 130);
    checkOutput("burst_final_cnt", bus.reg_bytecnt_o, 2);

    // alen low in the same cycle as an increment: clear wins.
    bus.cwusb_rdn_i = 1'b0;
    tick(4);
    bus.cwusb_alen_i = 1'b0;
    bus.cwusb_rdn_i = 1'b1;
    tick(6);
    checkOutput("alen_beats_inc", bus.reg_bytecnt_o, 0);
    bus.cwusb_alen_i = 1'b1;
    tick(3);
    checkOutput("alen_released_cnt", bus.reg_bytecnt_o, 0);

    // New read strobe during TURN: enable stays high, second pulse fires.
    preRd = rdPulses;
    bus.cwusb_rdn_i = 1'b0;
    tick(5);
    bus.cwusb_rdn_i = 1'b1;
    highCnt = 0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      if (bus.cwusb_isout_o) highCnt++;
      if (k == 2) bus.cwusb_rdn_i = 1'b0;
    end
    checkOutput("turn_rd_isout_continuous", highCnt, 7);
    tick(2);
    bus.cwusb_rdn_i = 1'b1;
    tick(7);
    checkOutput("turn_rd_pulses", rdPulses - preRd, 2);
    checkOutput("turn_rd_second_cnt", lastRdCnt, 1);
    checkOutput("turn_rd_cnt_after", bus.reg_bytecnt_o, 2);

    // Write strobe during TURN: enable drops as the FSM enters WR.
    preWr = wrPulses;
    bus.cwusb_rdn_i = 1'b0;
    tick(5);
    bus.cwusb_rdn_i = 1'b1;
    tick(2);
    bus.cwusb_addr_i = 8'h66; bus.cwusb_din_i = 8'h3C; bus.cwusb_wrn_i = 1'b0;
    tick(2);
    checkOutput("turn_wr_isout_before", bus.cwusb_isout_o, 1);
    tick(1);
    checkOutput("turn_wr_isout_in_wr", bus.cwusb_isout_o, 0);
    tick(2);
    bus.cwusb_wrn_i = 1'b1;
    tick(6);
    checkOutput("turn_wr_pulses", wrPulses - preWr, 1);
    checkOutput("turn_wr_addr", lastWrAddr, 8'h66);
    checkOutput("turn_wr_data", lastWrData, 8'h3C);
    checkOutput("turn_wr_cnt", lastWrCnt, 3);

    // Fast-FIFO bypass with chip select idle so no transaction starts.
    preRd = rdPulses; preWr = wrPulses;
    bus.cwusb_cen_i = 1'b1;
    tick(4);
    bus.fast_fifo_read_i = 1'b1;
    tick(1);
    checkOutput("ffr_isout_set", bus.cwusb_isout_o, 1);
    for (int k = 0; k < 4; k++) begin
      bus.reg_datai_i = 8'($urandom);
      #1;
      checkOutput($sformatf("ffr_bypass%0d", k), bus.cwusb_dout_o, bus.reg_datai_i);
      tick(1);
    end
    bus.cwusb_wrn_i = 1'b0;
    #1;
    checkOutput("ffr_isout_wrn_low", bus.cwusb_isout_o, 0);
    tick(1);
    bus.cwusb_wrn_i = 1'b1;
    #1;
    checkOutput("ffr_drive_cleared", bus.cwusb_isout_o, 0);
    bus.fast_fifo_read_i = 1'b0;
    bus.cwusb_cen_i = 1'b0;
    tick(4);
    checkOutput("ffr_no_pulses", (rdPulses - preRd) + (wrPulses - preWr), 0);

    // rd+wr overlap with chip select: sticky error, no pulses.
    preRd = rdPulses; preWr = wrPulses;
    checkOutput("proto_err_clear_before", bus.proto_err_o, 0);
    bus.cwusb_rdn_i = 1'b0; bus.cwusb_wrn_i = 1'b0;
    tick(6);
    checkOutput("proto_err_set", bus.proto_err_o, 1);
    checkOutput("proto_isout", bus.cwusb_isout_o, 0);
    checkOutput("proto_idle", bus.reg_addrvalid_o, 0);
    bus.cwusb_rdn_i = 1'b1; bus.cwusb_wrn_i = 1'b1;
    tick(6);
    checkOutput("proto_err_sticky", bus.proto_err_o, 1);
    checkOutput("proto_no_pulses", (rdPulses - preRd) + (wrPulses - preWr), 0);

    // Asynchronous reset in the middle of a write.
    preWr = wrPulses;
    bus.cwusb_addr_i = 8'h11; bus.cwusb_din_i = 8'h99; bus.cwusb_wrn_i = 1'b0;
    tick(5);
    checkOutput("midwr_addrvalid", bus.reg_addrvalid_o, 1);
    reset = 1'b1;
    #1;
    checkOutput("midwr_reset_address", bus.reg_address_o, 0);
    checkOutput("midwr_reset_bytecnt", bus.reg_bytecnt_o, 0);
    checkOutput("midwr_reset_datao", bus.reg_datao_o, 0);
    checkOutput("midwr_reset_dout", bus.cwusb_dout_o, 0);
    checkOutput("midwr_reset_flags", {bus.reg_read_o, bus.reg_write_o, bus.cwusb_isout_o,
                                      bus.reg_addrvalid_o, bus.proto_err_o}, 0);
    bus.cwusb_wrn_i = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(8);
    checkOutput("midwr_no_pulse_after", wrPulses - preWr, 0);

    // Randomised transactions against the transaction-level model.
    refCnt = 0;
    refDatao = 8'h00;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        alenPulse();
        refCnt = 0;
      end
      rWr = 1'($urandom_range(0, 1));
      rAddr = 8'($urandom);
      rData = 8'($urandom);
      preRd = rdPulses; preWr = wrPulses;
      applyStimulus(rWr, rAddr, rData, doutSeen);
      if (rWr) begin
        checkOutput($sformatf("rnd%0d_wr_pulses", i), {wrPulses - preWr, rdPulses - preRd}, {32'd1, 32'd0});
        checkOutput($sformatf("rnd%0d_wr_addr", i), lastWrAddr, rAddr);
        checkOutput($sformatf("rnd%0d_wr_data", i), lastWrData, rData);
        checkOutput($sformatf("rnd%0d_wr_cnt", i), lastWrCnt, refCnt);
        refDatao = rData;
      end else begin
        checkOutput($sformatf("rnd%0d_rd_pulses", i), {rdPulses - preRd, wrPulses - preWr}, {32'd1, 32'd0});
        checkOutput($sformatf("rnd%0d_rd_addr", i), lastRdAddr, rAddr);
        checkOutput($sformatf("rnd%0d_rd_cnt", i), lastRdCnt, refCnt);
        checkOutput($sformatf("rnd%0d_rd_dout", i), doutSeen, rData);
      end
      refCnt = (refCnt + 1) % 128;
      checkOutput($sformatf("rnd%0d_cnt_after", i), bus.reg_bytecnt_o, refCnt);
      checkOutput($sformatf("rnd%0d_datao", i), bus.reg_datao_o, refDatao);
      checkOutput($sformatf("rnd%0d_isout_idle", i), bus.cwusb_isout_o, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
